// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage that sits directly upstream of decode. It holds the
// program counter and issues one-word reads to instruction memory over a
// req/ack handshake, with at most one read outstanding. Returned words are
// queued in a small FIFO, which presents {instruction, PC} pairs to decode over
// a valid/ready handshake. A redirect from execute flushes the queue, restarts
// fetching at a new PC, and discards the data of any read still in flight.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   DEPTH        instruction FIFO entries (power of two, at least 2)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   mem_req      registered read request to instruction memory
//   mem_addr     registered word address of the request (bits [1:0] always 0)
//   mem_ack      read complete; mem_rdata valid this cycle
//   mem_rdata    read data
//   redirect     one-cycle pulse requesting a restart at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   inst_valid   FIFO head holds a valid instruction
//   inst_ready   decode accepts the head entry this cycle
//   inst         instruction word at the FIFO head
//   inst_pc      PC of inst

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // RUN is normal operation; DROP means the single outstanding request is
  // stale and its data must be thrown away when the ack finally arrives.
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          ack;
  logic          in_run;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] count_next;
  logic [31:0]   redirect_target;

  // The head entry drives decode directly. While the FIFO is empty these keep
  // showing whatever slot rd_ptr points at, which decode ignores.
  assign inst_valid = in_run && (count != '0);
  assign inst       = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Handshake decode and the issue decision. A redirect cancels both the push
  // and the pop of this cycle, because the whole FIFO is being flushed anyway.
  // A new request may only go out once the previous one completes and the
  // FIFO, after this cycle's push/pop, still has a free slot for its data.
  // That slot check is what guarantees the FIFO can never overflow.
  always_comb begin
    ack             = mem_req & mem_ack;
    in_run          = (state == RUN);
    push            = in_run & ack & ~redirect;
    pop             = inst_valid & inst_ready & ~redirect;
    count_next      = redirect ? '0 : (count + CW'(push) - CW'(pop));
    issue           = in_run & ~redirect & (~mem_req | mem_ack) & (count_next < DEPTH_C);
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
  end

  // FIFO storage and pointers. The storage is cleared on reset so that inst
  // and inst_pc read as zero immediately after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= mem_rdata;
          fifo_pc[wr_ptr]   <= mem_addr;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // PC, request and RUN/DROP control. An outstanding request is never
  // aborted: mem_req and mem_addr hold until the ack. A redirect that lands
  // while a request is still waiting sends us to DROP so its data is
  // discarded; if the ack arrives in the same cycle as the redirect, the data
  // is simply not pushed and we stay in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            pc <= redirect_target;
            if (mem_req && !mem_ack) begin
              state <= DROP;
            end else begin
              mem_req <= 1'b0;
            end
          end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            pc       <= pc + 32'd4;
          end else if (ack) begin
            mem_req <= 1'b0;
          end
        end
        DROP: begin
          if (redirect) begin
            pc <= redirect_target;
          end
          if (ack) begin
            mem_req <= 1'b0;
            state   <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// -------------
// Directed testbench for fetch_unit (RESET_PC=0, DEPTH=2). A behavioural
// instruction memory answers requests after a programmable latency with data
// equal to address + 0x1000_0000, or with an override word when enabled. A
// small monitor counts any presentation of a forbidden PC/word to decode, or
// any request to a forbidden address, so discarded fetches can be checked.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int assertCount = 0;
  int failCount   = 0;

  int          latency      = 0;
  logic        overrideOn   = 1'b0;
  logic [31:0] overrideData = 32'hDEAD_BEEF;
  int          waitCnt      = 0;
  int          ackCount     = 0;

  logic        forbidOn   = 1'b0;
  logic [31:0] forbidPc   = '0;
  logic [31:0] forbidData = '0;
  logic [31:0] forbidAddr = '0;
  int          badSeen    = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: acks a request after 'latency' waiting cycles,
  // counting from the cycle mem_req is first seen (latency 0 = same cycle).
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end else if (waitCnt >= latency) begin
      mem_ack   = 1'b1;
      mem_rdata = overrideOn ? overrideData : (mem_addr + 32'h1000_0000);
      waitCnt   = 0;
      ackCount++;
    end else begin
      mem_ack = 1'b0;
      waitCnt++;
    end
  end

  // Watches for discarded fetches leaking to decode or abandoned PCs being requested.
  always @(negedge clk) begin
    if (forbidOn) begin
      if (inst_valid && (inst_pc == forbidPc || inst == forbidData)) badSeen++;
      if (mem_req && mem_addr == forbidAddr) badSeen++;
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rdy);
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    int   base;
    int   a0;
    logic found;

    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    step();

    // Reset state
    checkOutput("rst mem_req",    mem_req,    1'b0);
    checkOutput("rst mem_addr",   mem_addr,   32'h0);
    checkOutput("rst inst_valid", inst_valid, 1'b0);
    checkOutput("rst inst",       inst,       32'h0);
    checkOutput("rst inst_pc",    inst_pc,    32'h0);

    // Zero-wait memory, decode always ready: back-to-back fetches
    latency = 0;
    reset   = 1'b0;
    step();
    checkOutput("t1 c1 mem_req",    mem_req,    1'b1);
    checkOutput("t1 c1 mem_addr",   mem_addr,   32'h0);
    checkOutput("t1 c1 inst_valid", inst_valid, 1'b0);
    step();
    checkOutput("t1 c2 mem_addr",   mem_addr,   32'h4);
    checkOutput("t1 c2 inst_valid", inst_valid, 1'b1);
    checkOutput("t1 c2 inst_pc",    inst_pc,    32'h0);
    checkOutput("t1 c2 inst",       inst,       32'h1000_0000);
    step();
    checkOutput("t1 c3 mem_addr",   mem_addr,   32'h8);
    checkOutput("t1 c3 inst_pc",    inst_pc,    32'h4);
    checkOutput("t1 c3 inst",       inst,       32'h1000_0004);

    // Decode stalled: FIFO fills to DEPTH, fetch stops, then drains in order
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyReset();
    a0 = ackCount;
    step();
    checkOutput("t2 c1 mem_addr", mem_addr, 32'h0);
    step();
    checkOutput("t2 c2 inst_pc",  inst_pc,  32'h0);
    checkOutput("t2 c2 mem_addr", mem_addr, 32'h4);
    step();
    checkOutput("t2 c3 mem_req",  mem_req,  1'b0);
    step();
    step();
    checkOutput("t2 c5 mem_req",    mem_req,    1'b0);
    checkOutput("t2 c5 inst_valid", inst_valid, 1'b1);
    checkOutput("t2 c5 inst_pc",    inst_pc,    32'h0);
    checkOutput("t2 c5 inst",       inst,       32'h1000_0000);
    checkOutput("t2 ack count",     ackCount - a0, 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t2 c6 inst_pc",  inst_pc,  32'h4);
    checkOutput("t2 c6 mem_req",  mem_req,  1'b1);
    checkOutput("t2 c6 mem_addr", mem_addr, 32'h8);
    step();
    checkOutput("t2 c7 inst_pc",  inst_pc,  32'h8);
    checkOutput("t2 c7 inst",     inst,     32'h1000_0008);

    // 3-cycle memory, redirect one cycle after the request to 0x10 rises
    applyStimulus(1'b0, 32'h0, 1'b1);
    latency = 3;
    applyReset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 32'h10) found = 1'b1;
    end
    checkOutput("t3 reached 0x10", found, 1'b1);
    forbidPc   = 32'h10;
    forbidData = 32'h1000_0010;
    forbidAddr = 32'hFFFF_FFF0;
    base       = badSeen;
    forbidOn   = 1'b1;
    step();
    applyStimulus(1'b1, 32'h1003, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3 c2 mem_req",    mem_req,    1'b1);
    checkOutput("t3 c2 mem_addr",   mem_addr,   32'h10);
    checkOutput("t3 c2 inst_valid", inst_valid, 1'b0);
    step();
    checkOutput("t3 c3 mem_addr",   mem_addr,   32'h10);
    checkOutput("t3 c3 inst_valid", inst_valid, 1'b0);
    step();
    checkOutput("t3 c4 mem_req",    mem_req,    1'b0);
    checkOutput("t3 c4 inst_valid", inst_valid, 1'b0);
    step();
    checkOutput("t3 c5 mem_req",    mem_req,    1'b1);
    checkOutput("t3 c5 mem_addr",   mem_addr,   32'h1000);
    repeat (4) step();
    checkOutput("t3 c9 inst_valid", inst_valid, 1'b1);
    checkOutput("t3 c9 inst_pc",    inst_pc,    32'h1000);
    checkOutput("t3 c9 inst",       inst,       32'h1000_1000);
    forbidOn = 1'b0;
    checkOutput("t3 stale leaked",  badSeen - base, 32'd0);

    // Redirect coincident with an ack carrying 0xDEADBEEF
    applyStimulus(1'b0, 32'h0, 1'b0);
    latency = 0;
    applyReset();
    step();
    overrideOn = 1'b1;
    forbidPc   = 32'h4;
    forbidData = 32'hDEAD_BEEF;
    forbidAddr = 32'hFFFF_FFF0;
    base       = badSeen;
    forbidOn   = 1'b1;
    step();
    checkOutput("t4 c2 inst_valid", inst_valid, 1'b1);
    checkOutput("t4 c2 inst_pc",    inst_pc,    32'h0);
    checkOutput("t4 c2 mem_addr",   mem_addr,   32'h4);
    applyStimulus(1'b1, 32'h200, 1'b0);
    overrideOn = 1'b0;
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4 c3 inst_valid", inst_valid, 1'b0);
    checkOutput("t4 c3 mem_req",    mem_req,    1'b0);
    step();
    checkOutput("t4 c4 mem_req",    mem_req,    1'b1);
    checkOutput("t4 c4 mem_addr",   mem_addr,   32'h200);
    step();
    checkOutput("t4 c5 inst_valid", inst_valid, 1'b1);
    checkOutput("t4 c5 inst_pc",    inst_pc,    32'h200);
    checkOutput("t4 c5 inst",       inst,       32'h1000_0200);
    forbidOn = 1'b0;
    checkOutput("t4 discarded leaked", badSeen - base, 32'd0);

    // Two redirects (0x300 then 0x400) during one stale request
    applyStimulus(1'b0, 32'h0, 1'b1);
    latency = 3;
    applyReset();
    step();
    forbidPc   = 32'h0;
    forbidData = 32'h1000_0000;
    forbidAddr = 32'h300;
    base       = badSeen;
    forbidOn   = 1'b1;
    checkOutput("t5 c1 mem_addr", mem_addr, 32'h0);
    applyStimulus(1'b1, 32'h300, 1'b1);
    step();
    applyStimulus(1'b1, 32'h400, 1'b1);
    checkOutput("t5 c2 inst_valid", inst_valid, 1'b0);
    checkOutput("t5 c2 mem_addr",   mem_addr,   32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5 c3 mem_req",    mem_req,    1'b1);
    step();
    checkOutput("t5 c4 inst_valid", inst_valid, 1'b0);
    step();
    checkOutput("t5 c5 mem_req",    mem_req,    1'b0);
    step();
    checkOutput("t5 c6 mem_req",    mem_req,    1'b1);
    checkOutput("t5 c6 mem_addr",   mem_addr,   32'h400);
    repeat (4) step();
    checkOutput("t5 c10 inst_pc",   inst_pc,    32'h400);
    checkOutput("t5 c10 inst",      inst,       32'h1000_0400);
    forbidOn = 1'b0;
    checkOutput("t5 stale leaked",  badSeen - base, 32'd0);

    // Asynchronous reset with a request pending and one FIFO entry
    applyStimulus(1'b0, 32'h0, 1'b0);
    latency = 3;
    applyReset();
    repeat (5) step();
    checkOutput("t6 pre inst_valid", inst_valid, 1'b1);
    checkOutput("t6 pre inst_pc",    inst_pc,    32'h0);
    checkOutput("t6 pre mem_req",    mem_req,    1'b1);
    checkOutput("t6 pre mem_addr",   mem_addr,   32'h4);
    reset = 1'b1;
    #1;
    checkOutput("t6 async mem_req",    mem_req,    1'b0);
    checkOutput("t6 async inst_valid", inst_valid, 1'b0);
    checkOutput("t6 async mem_addr",   mem_addr,   32'h0);
    step();
    reset = 1'b0;
    step();
    checkOutput("t6 post mem_req",  mem_req,  1'b1);
    checkOutput("t6 post mem_addr", mem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
